// File: rtl/instruction_fetch_unit.sv
// Fetch stage: issues word requests to the I-cache, buffers one response for decode
// stalls and squashes in-flight responses after a branch/jump redirect.
module instruction_fetch_unit #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        icache_req,
   output logic [31:0] icache_addr,
   input  logic        icache_rvalid,
   input  logic [31:0] icache_rdata,
   input  logic        stall,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic [31:0] instr,
   output logic [31:0] pc_out,
   output logic [31:0] pc_plus4,
   output logic        instr_valid
);

   typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;

   state_t      state;
   logic [31:0] fetch_pc;
   logic        kill;
   logic [31:0] kill_pc;
   logic [31:0] skid_instr;
   logic [31:0] skid_pc;

   logic accept;
   logic load_out;
   logic to_skid;
   logic from_skid;
   logic consume;

   function automatic logic [31:0] next_word(input logic [31:0] pc);
      return pc + 32'd4;
   endfunction

   function automatic logic [31:0] align_word(input logic [31:0] a);
      return a & 32'hFFFF_FFFC;
   endfunction

   assign icache_addr = fetch_pc;

   // A response is usable only when no redirect is squashing it, now or earlier.
   assign accept    = (state == WAIT) && icache_rvalid && !kill && !redirect;
   assign load_out  = accept && (!instr_valid || !stall);
   assign to_skid   = accept && instr_valid && stall;
   assign from_skid = (state == HOLD) && !stall && !redirect;
   assign consume   = !stall && !load_out && !from_skid;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         fetch_pc    <= align_word(RESET_PC);
         kill        <= 1'b0;
         kill_pc     <= '0;
         icache_req  <= 1'b0;
         instr       <= NOP_INSTR;
         pc_out      <= '0;
         pc_plus4    <= '0;
         instr_valid <= 1'b0;
      end else begin
         if (redirect || consume) begin
            instr_valid <= 1'b0;
            instr       <= NOP_INSTR;
         end else if (load_out) begin
            instr       <= icache_rdata;
            pc_out      <= fetch_pc;
            pc_plus4    <= next_word(fetch_pc);
            instr_valid <= 1'b1;
         end else if (from_skid) begin
            instr       <= skid_instr;
            pc_out      <= skid_pc;
            pc_plus4    <= next_word(skid_pc);
            instr_valid <= 1'b1;
         end

         if (redirect) begin
            // An outstanding miss keeps its address until answered; the target waits in kill_pc.
            if (state == WAIT && !icache_rvalid) begin
               kill    <= 1'b1;
               kill_pc <= align_word(redirect_pc);
            end else begin
               kill     <= 1'b0;
               fetch_pc <= align_word(redirect_pc);
            end
            state      <= WAIT;
            icache_req <= 1'b1;
         end else begin
            case (state)
               IDLE: begin
                  state      <= WAIT;
                  icache_req <= 1'b1;
               end
               WAIT: begin
                  if (icache_rvalid) begin
                     if (kill) begin
                        fetch_pc <= kill_pc;
                        kill     <= 1'b0;
                     end else begin
                        fetch_pc <= next_word(fetch_pc);
                     end
                     if (to_skid) begin
                        state      <= HOLD;
                        icache_req <= 1'b0;
                     end
                  end
               end
               HOLD: begin
                  if (!stall) begin
                     state      <= WAIT;
                     icache_req <= 1'b1;
                  end
               end
               default: begin
                  state      <= IDLE;
                  icache_req <= 1'b0;
               end
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (to_skid) begin
         skid_instr <= icache_rdata;
         skid_pc    <= fetch_pc;
      end
   end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: directed scenarios plus a randomized run checked
// against an in-order fetch-stream model with a latency-programmable I-cache responder.
module tb_instruction_fetch_unit;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        icache_req;
   logic [31:0] icache_addr;
   logic        icache_rvalid = 1'b0;
   logic [31:0] icache_rdata  = 32'h0;
   logic        stall;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic [31:0] instr;
   logic [31:0] pc_out;
   logic [31:0] pc_plus4;
   logic        instr_valid;

   logic        w_req;
   logic [31:0] w_addr;
   logic        w_rvalid;
   logic [31:0] w_rdata;
   logic [31:0] w_instr;
   logic [31:0] w_pc;
   logic [31:0] w_pc4;
   logic        w_valid;
   logic        w_stall = 1'b0;
   logic        w_redirect = 1'b0;
   logic [31:0] w_redirect_pc = 32'h0;

   int total = 0;
   int bad   = 0;

   logic [31:0] miss_addr = 32'h1;
   int          miss_lat  = 0;
   bit          rand_lat  = 1'b0;
   bit          busy      = 1'b0;
   int          cnt       = 0;
   int          cur_lat   = 0;

   always #5 clk = ~clk;

   instruction_fetch_unit dut (
      .clk(clk), .rst_n(rst_n),
      .icache_req(icache_req), .icache_addr(icache_addr),
      .icache_rvalid(icache_rvalid), .icache_rdata(icache_rdata),
      .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
      .instr(instr), .pc_out(pc_out), .pc_plus4(pc_plus4), .instr_valid(instr_valid)
   );

   instruction_fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
      .clk(clk), .rst_n(rst_n),
      .icache_req(w_req), .icache_addr(w_addr),
      .icache_rvalid(w_rvalid), .icache_rdata(w_rdata),
      .stall(w_stall), .redirect(w_redirect), .redirect_pc(w_redirect_pc),
      .instr(w_instr), .pc_out(w_pc), .pc_plus4(w_pc4), .instr_valid(w_valid)
   );

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a >> 2;
   endfunction

   function automatic int pick_lat(input logic [31:0] a);
      if (a == miss_addr) return miss_lat;
      if (rand_lat) return int'($urandom_range(0, 3));
      return 0;
   endfunction

   // Always-hit cache for the wrap-around instance.
   assign w_rvalid = w_req;
   assign w_rdata  = mem_word(w_addr);

   // Cache responder: each request is answered after its chosen number of wait cycles.
   always @(negedge clk) begin
      if (!rst_n || !icache_req) begin
         busy          = 1'b0;
         icache_rvalid = 1'b0;
      end else begin
         if (icache_rvalid) busy = 1'b0;
         if (!busy) begin
            busy    = 1'b1;
            cnt     = 0;
            cur_lat = pick_lat(icache_addr);
         end else begin
            cnt++;
         end
         icache_rvalid = (cnt >= cur_lat);
         icache_rdata  = icache_rvalid ? mem_word(icache_addr) : 32'hDEAD_BEEF;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n    = 1'b0;
      stall    = 1'b0;
      redirect = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #1;
      total++;
      if ({icache_req, instr_valid} !== 2'b00) begin
         bad++; $display("FAIL reset_ctrl got req,valid=%b%b exp=00", icache_req, instr_valid);
      end
      total++;
      if ({instr, pc_out, pc_plus4} !== {NOP, 32'h0, 32'h0}) begin
         bad++; $display("FAIL reset_data got instr=%h pc=%h pc4=%h exp=%h 0 0", instr, pc_out, pc_plus4, NOP);
      end
      do_reset();
      tick();
      total++;
      if ({instr_valid, icache_req, icache_addr} !== {1'b0, 1'b1, 32'h0}) begin
         bad++; $display("FAIL first_req got valid=%b req=%b addr=%h exp valid=0 req=1 addr=0", instr_valid, icache_req, icache_addr);
      end
      tick();
      total++;
      if ({instr_valid, pc_out, instr, pc_plus4} !== {1'b1, 32'h0, 32'h0, 32'h4}) begin
         bad++; $display("FAIL first_instr got valid=%b pc=%h instr=%h pc4=%h exp 1 0 0 4", instr_valid, pc_out, instr, pc_plus4);
      end
   endtask

   task automatic test_hits();
      logic [31:0] e;
      for (int k = 1; k <= 6; k++) begin
         tick();
         e = 32'(4 * k);
         total++;
         if ({instr_valid, pc_out, instr, pc_plus4} !== {1'b1, e, e >> 2, e + 32'd4}) begin
            bad++; $display("FAIL hit_stream got valid=%b pc=%h instr=%h pc4=%h exp pc=%h", instr_valid, pc_out, instr, pc_plus4, e);
         end
      end
   endtask

   task automatic test_miss();
      miss_addr = 32'h8;
      miss_lat  = 2;
      do_reset();
      repeat (3) tick();
      total++;
      if ({instr_valid, pc_out, icache_req, icache_addr} !== {1'b1, 32'h4, 1'b1, 32'h8}) begin
         bad++; $display("FAIL miss_start got valid=%b pc=%h req=%b addr=%h exp 1 4 1 8", instr_valid, pc_out, icache_req, icache_addr);
      end
      for (int i = 0; i < 2; i++) begin
         tick();
         total++;
         if ({instr_valid, instr, icache_req, icache_addr} !== {1'b0, NOP, 1'b1, 32'h8}) begin
            bad++; $display("FAIL miss_wait got valid=%b instr=%h req=%b addr=%h exp 0 nop 1 8", instr_valid, instr, icache_req, icache_addr);
         end
      end
      tick();
      total++;
      if ({instr_valid, pc_out, instr} !== {1'b1, 32'h8, 32'h2}) begin
         bad++; $display("FAIL miss_data got valid=%b pc=%h instr=%h exp 1 8 2", instr_valid, pc_out, instr);
      end
      tick();
      total++;
      if ({instr_valid, pc_out} !== {1'b1, 32'hC}) begin
         bad++; $display("FAIL miss_after got valid=%b pc=%h exp 1 c", instr_valid, pc_out);
      end
      miss_addr = 32'h1;
   endtask

   task automatic test_stall();
      do_reset();
      repeat (3) tick();
      stall = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         total++;
         if ({instr_valid, pc_out, instr, icache_req} !== {1'b1, 32'h4, 32'h1, 1'b0}) begin
            bad++; $display("FAIL stall_hold got valid=%b pc=%h instr=%h req=%b exp 1 4 1 0", instr_valid, pc_out, instr, icache_req);
         end
      end
      stall = 1'b0;
      tick();
      total++;
      if ({instr_valid, pc_out, instr, icache_req, icache_addr} !== {1'b1, 32'h8, 32'h2, 1'b1, 32'hC}) begin
         bad++; $display("FAIL skid_out got valid=%b pc=%h instr=%h req=%b addr=%h exp 1 8 2 1 c", instr_valid, pc_out, instr, icache_req, icache_addr);
      end
      for (int k = 3; k <= 4; k++) begin
         tick();
         total++;
         if ({instr_valid, pc_out} !== {1'b1, 32'(4 * k)}) begin
            bad++; $display("FAIL after_skid got valid=%b pc=%h exp pc=%h", instr_valid, pc_out, 32'(4 * k));
         end
      end
   endtask

   task automatic test_kill();
      miss_addr = 32'h20;
      miss_lat  = 3;
      do_reset();
      repeat (9) tick();
      total++;
      if ({pc_out, icache_addr} !== {32'h1C, 32'h20}) begin
         bad++; $display("FAIL kill_setup got pc=%h addr=%h exp 1c 20", pc_out, icache_addr);
      end
      redirect    = 1'b1;
      redirect_pc = 32'h103;
      tick();
      redirect = 1'b0;
      for (int i = 0; i < 3; i++) begin
         total++;
         if ({instr_valid, instr, icache_req, icache_addr} !== {1'b0, NOP, 1'b1, 32'h20}) begin
            bad++; $display("FAIL kill_hold got valid=%b instr=%h req=%b addr=%h exp 0 nop 1 20", instr_valid, instr, icache_req, icache_addr);
         end
         tick();
      end
      total++;
      if ({instr_valid, icache_req, icache_addr} !== {1'b0, 1'b1, 32'h100}) begin
         bad++; $display("FAIL kill_discard got valid=%b req=%b addr=%h exp 0 1 100", instr_valid, icache_req, icache_addr);
      end
      tick();
      total++;
      if ({instr_valid, pc_out, instr, pc_plus4} !== {1'b1, 32'h100, 32'h40, 32'h104}) begin
         bad++; $display("FAIL kill_target got valid=%b pc=%h instr=%h pc4=%h exp 1 100 40 104", instr_valid, pc_out, instr, pc_plus4);
      end
      miss_addr = 32'h1;
   endtask

   task automatic test_redirect_stall();
      do_reset();
      repeat (3) tick();
      stall = 1'b1;
      repeat (2) tick();
      redirect    = 1'b1;
      redirect_pc = 32'h40;
      tick();
      redirect = 1'b0;
      total++;
      if ({instr_valid, instr, icache_req, icache_addr} !== {1'b0, NOP, 1'b1, 32'h40}) begin
         bad++; $display("FAIL redir_flush got valid=%b instr=%h req=%b addr=%h exp 0 nop 1 40", instr_valid, instr, icache_req, icache_addr);
      end
      stall = 1'b0;
      tick();
      total++;
      if ({instr_valid, pc_out, instr} !== {1'b1, 32'h40, 32'h10}) begin
         bad++; $display("FAIL redir_first got valid=%b pc=%h instr=%h exp 1 40 10", instr_valid, pc_out, instr);
      end
      tick();
      total++;
      if ({instr_valid, pc_out} !== {1'b1, 32'h44}) begin
         bad++; $display("FAIL redir_next got valid=%b pc=%h exp 1 44", instr_valid, pc_out);
      end
   endtask

   task automatic test_wrap();
      logic [31:0] exp_pc;
      do_reset();
      tick();
      exp_pc = 32'hFFFF_FFF8;
      for (int k = 0; k < 4; k++) begin
         tick();
         total++;
         if ({w_valid, w_pc, w_pc4, w_instr} !== {1'b1, exp_pc, exp_pc + 32'd4, exp_pc >> 2}) begin
            bad++; $display("FAIL wrap got valid=%b pc=%h pc4=%h instr=%h exp pc=%h", w_valid, w_pc, w_pc4, w_instr, exp_pc);
         end
         exp_pc = exp_pc + 32'd4;
      end
   endtask

   task automatic test_reset_mid_miss();
      miss_addr = 32'h8;
      miss_lat  = 10;
      do_reset();
      repeat (3) tick();
      stall = 1'b1;
      repeat (2) tick();
      total++;
      if ({instr_valid, pc_out, icache_req, icache_addr} !== {1'b1, 32'h4, 1'b1, 32'h8}) begin
         bad++; $display("FAIL miss_stall got valid=%b pc=%h req=%b addr=%h exp 1 4 1 8", instr_valid, pc_out, icache_req, icache_addr);
      end
      rst_n = 1'b0;
      #1;
      total++;
      if ({icache_req, instr_valid, instr, pc_out, pc_plus4} !== {1'b0, 1'b0, NOP, 32'h0, 32'h0}) begin
         bad++; $display("FAIL async_reset got req=%b valid=%b instr=%h pc=%h pc4=%h", icache_req, instr_valid, instr, pc_out, pc_plus4);
      end
      stall     = 1'b0;
      miss_addr = 32'h1;
      do_reset();
   endtask

   task automatic test_random();
      logic [31:0] exp_pc, prev_pc, prev_instr, prev_addr, prev_tgt;
      logic        prev_valid, prev_stall, prev_redir, prev_req, rv;
      int          idle;
      rand_lat = 1'b1;
      do_reset();
      exp_pc = 32'h0;
      prev_valid = 1'b0; prev_stall = 1'b0; prev_redir = 1'b0; prev_req = 1'b0;
      prev_pc = 32'h0; prev_instr = NOP; prev_addr = 32'h0; prev_tgt = 32'h0;
      idle = 0;
      for (int n = 0; n < 800; n++) begin
         tick();
         rv = icache_rvalid;
         if (prev_redir) begin
            exp_pc = prev_tgt & 32'hFFFF_FFFC;
            idle++;
            total++;
            if (instr_valid !== 1'b0) begin
               bad++; $display("FAIL rnd_flush got valid=%b exp 0", instr_valid);
            end
         end else begin
            if (prev_valid && !prev_stall) begin
               total++;
               if (prev_pc !== exp_pc) begin
                  bad++; $display("FAIL rnd_order got pc=%h exp %h", prev_pc, exp_pc);
               end
               exp_pc = exp_pc + 32'd4;
               idle   = 0;
            end else begin
               idle++;
            end
            if (prev_valid && prev_stall) begin
               total++;
               if ({instr_valid, pc_out, instr} !== {1'b1, prev_pc, prev_instr}) begin
                  bad++; $display("FAIL rnd_stall got valid=%b pc=%h instr=%h exp 1 %h %h", instr_valid, pc_out, instr, prev_pc, prev_instr);
               end
            end
         end
         if (prev_req && !rv) begin
            total++;
            if ({icache_req, icache_addr} !== {1'b1, prev_addr}) begin
               bad++; $display("FAIL rnd_req_stable got req=%b addr=%h exp 1 %h", icache_req, icache_addr, prev_addr);
            end
         end
         total++;
         if (icache_addr[1:0] !== 2'b00) begin
            bad++; $display("FAIL rnd_align got addr=%h", icache_addr);
         end
         total++;
         if (instr_valid) begin
            if (instr !== mem_word(pc_out) || pc_plus4 !== pc_out + 32'd4) begin
               bad++; $display("FAIL rnd_payload got pc=%h instr=%h pc4=%h exp instr=%h", pc_out, instr, pc_plus4, mem_word(pc_out));
            end
         end else if (instr !== NOP) begin
            bad++; $display("FAIL rnd_nop got instr=%h exp %h", instr, NOP);
         end
         if (idle > 60) begin
            total++; bad++;
            $display("FAIL rnd_progress got %0d idle cycles exp <= 60", idle);
            break;
         end
         prev_valid = instr_valid;
         prev_pc    = pc_out;
         prev_instr = instr;
         prev_req   = icache_req;
         prev_addr  = icache_addr;
         stall       = ($urandom_range(0, 9) < 3);
         redirect    = ($urandom_range(0, 19) == 0);
         redirect_pc = $urandom();
         prev_stall = stall;
         prev_redir = redirect;
         prev_tgt   = redirect_pc;
      end
      stall    = 1'b0;
      redirect = 1'b0;
      rand_lat = 1'b0;
   endtask

   initial begin
      rst_n       = 1'b0;
      stall       = 1'b0;
      redirect    = 1'b0;
      redirect_pc = 32'h0;
      repeat (2) @(posedge clk);
      #1;
      test_reset();
      test_hits();
      test_miss();
      test_stall();
      test_kill();
      test_redirect_stall();
      test_wrap();
      test_reset_mid_miss();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog simulation did not finish within time limit");
      $fatal(1);
   end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
Fetch stage of the single-issue RISC-V core. It holds the fetch PC, issues word requests to the instruction cache, and tolerates multi-cycle misses. It presents each fetched instruction with its PC and PC+4 to decode, which feeds instr[31:7] to the immediate extender. Includes a one-entry skid buffer for decode stalls and a kill mechanism for branch/jump redirects.

Parameters:
RESET_PC, 32'h0000_0000, fetch address after reset (bits [1:0] must be 0)
NOP_INSTR, 32'h0000_0013, value driven on instr when no valid instruction is held (addi x0,x0,0)

Ports:
clk  input  1  core clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
icache_req  output  1  fetch request; held high with stable icache_addr until icache_rvalid
icache_addr  output  32  word-aligned fetch address
icache_rvalid  input  1  response valid; may assert in the same cycle as icache_req (hit) or any later cycle (miss)
icache_rdata  input  32  instruction word, valid when icache_rvalid=1
stall  input  1  decode cannot accept; holds instr/pc outputs
redirect  input  1  taken branch/jump; flush and refetch
redirect_pc  input  32  new fetch address; bits [1:0] forced to 0
instr  output  32  instruction to decode
pc_out  output  32  PC of instr
pc_plus4  output  32  pc_out + 4, modulo 2^32
instr_valid  output  1  instr/pc_out/pc_plus4 are meaningful

Behaviour:
- Reset (async, rst_n=0): state=IDLE, fetch_pc=RESET_PC, instr=NOP_INSTR, pc_out=0, pc_plus4=0, instr_valid=0, skid empty, kill=0, icache_req=0. Reset mid-miss abandons the request; the cache must tolerate req dropping.
- States:
  - IDLE: one cycle after reset release, icache_req=0, then go to WAIT.
  - WAIT: icache_req=1, icache_addr=fetch_pc.
  - HOLD: skid full, icache_req=0.
- Transitions and actions, on a clock edge in WAIT with icache_rvalid=1 and kill=0:
  - If the output slot is free or being consumed (instr_valid=0 or stall=0): load instr=icache_rdata, pc_out=fetch_pc, pc_plus4=fetch_pc+4, instr_valid=1. Set fetch_pc+=4 and stay in WAIT. A hit every cycle gives 1 instruction/cycle.
  - Else (instr_valid=1 and stall=1): write the word and its PC into the skid, set fetch_pc+=4, go to HOLD.
- HOLD with stall=0: move skid to outputs, empty the skid, go to WAIT. Skid entries are never lost or reordered.
- Consume with stall=0 and no new response: instr_valid<=0 and instr<=NOP_INSTR. pc_out and pc_plus4 hold their values.
- Redirect has the highest priority and overrides stall:
  - Clear instr_valid, drive instr=NOP_INSTR, empty the skid, set fetch_pc={redirect_pc[31:2],2'b00}.
  - If in WAIT with icache_rvalid=0: set kill=1 and stay in WAIT with the old address held (protocol stability). When icache_rvalid arrives, discard the data, clear kill, and present the redirected address the next cycle.
  - If in WAIT with icache_rvalid=1: discard the data, kill stays 0, and the new address is presented the next cycle.
  - If in HOLD or IDLE: go to WAIT.
- A redirect while kill=1 updates the pending target only; the last redirect wins.
- fetch_pc wraps from 32'hFFFF_FFFC to 0.
- icache_addr[1:0] is always 0.
- Latency: with a hit, instr_valid rises on the edge after the cycle icache_req/icache_rvalid are high.

Test Plan:
- Reset, then constant hits (rvalid=1 whenever req=1), memory[i]=i → first instr_valid on the 2nd edge after reset release, pc_out=0,4,8,... on consecutive cycles, instr=0,1,2,..., pc_plus4=pc_out+4.
- 3-cycle miss at addr 0x8 → icache_req/addr 0x8 stable 3 cycles, instr_valid=0 during the miss (after draining 0x4), then instr from 0x8 valid once.
- stall high for 4 cycles during hits → outputs frozen at the current instr, exactly one extra word captured in the skid, icache_req=0 in HOLD. Release → the skid word appears next; no duplicates or gaps in the PC sequence.
- redirect to 0x103 during a miss at 0x20 → req addr stays 0x20 until rvalid, data discarded (instr_valid stays 0), next request 0x100, delivered instr has pc_out=0x100.
- redirect together with stall=1 while the skid is full → instr_valid=0 next cycle, skid emptied, next fetch from redirect target.
- RESET_PC=0xFFFF_FFF8 with hits → pc_out sequence FFFF_FFF8, FFFF_FFFC, 0, 4. Assert rst_n=0 mid-miss → all outputs return to reset values immediately.
